lms_gpio_ctrl: RTL and testbench



---
 rtl/lms_gpio_pkg.sv | 28 ++
 rtl/lms_gpio_if.sv | 29 ++
 rtl/lms_gpio_debounce.sv | 34 +++
 rtl/lms_gpio_ctrl.sv | 145 ++++++++++++++
 tb/tb_lms_gpio_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lms_gpio_pkg.sv
// Shared constants for the LMS GPIO controller: register word addresses,
// edge-type encodings and a counter-width helper.
package lms_gpio_pkg;

    localparam logic [2:0] GPIO_ADDR_DATA    = 3'd0;
    localparam logic [2:0] GPIO_ADDR_DIR     = 3'd1;
    localparam logic [2:0] GPIO_ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] GPIO_ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] GPIO_ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] GPIO_ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lms_gpio_if.sv
// Avalon-MM slave bus bundle for the LMS GPIO controller (32-bit data, 3-bit word address).
interface lms_gpio_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output read_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  read_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/lms_gpio_debounce.sv
// Single-bit debouncer: the output follows the input only after it has
// differed for DEBOUNCE_CYC consecutive cycles. Used under LMS_GPIO_DEBOUNCE_EN.
module lms_gpio_debounce
    import lms_gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int              CNT_W    = clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Any cycle where input matches output restarts the stability window.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            dout <= din;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lms_gpio_ctrl.sv
// Avalon-MM GPIO controller: per-bit direction, synchronised inputs, edge capture
// with masked level IRQ and atomic set/clear. Optional macro: LMS_GPIO_DEBOUNCE_EN.
module lms_gpio_ctrl
    import lms_gpio_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] RESET_OUT    = WIDTH'('h3),
    parameter logic [WIDTH-1:0] RESET_DIR    = '0,
    parameter int               EDGE_TYPE    = 0,
    parameter int               DEBOUNCE_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    lms_gpio_if.slave        bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] in_prev;
    logic [1:0]       warm_cnt;
    logic             warm;

    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [31:0]      rd_word;

    assign wr           = bus.chipselect & ~bus.write_n;
    assign rd           = bus.chipselect & ~bus.read_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    // Stage p0/p1: two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= gpio_in;
            sync_p1 <= sync_p0;
        end
    end

`ifdef LMS_GPIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        lms_gpio_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .din  (sync_p1[i]),
            .dout (in_q[i])
        );
    end
`else
    assign in_q = sync_p1;
`endif

    // Edge stage: in_prev follows in_q regardless of direction, so flipping
    // DIR never fabricates an edge. Warm-up hides the post-reset sync ramp.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_prev  <= '0;
            warm_cnt <= 2'd0;
        end else begin
            in_prev <= in_q;
            if (warm_cnt != 2'd3) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
        end
    end

    assign warm = (warm_cnt == 2'd3);

    always_comb begin
        edge_det = in_q & ~in_prev;
        case (EDGE_TYPE)
            EDGE_FALL: edge_det = ~in_q & in_prev;
            EDGE_ANY:  edge_det = in_q ^ in_prev;
            default:   ;
        endcase
    end

    assign edge_set = warm ? (edge_det & ~gpio_oe) : '0;
    assign edge_clr = (wr && bus.address == GPIO_ADDR_EDGECAP) ? wdata : '0;

    // Register file; a new edge outranks a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out <= RESET_OUT;
            gpio_oe  <= RESET_DIR;
            irqmask  <= '0;
            edgecap  <= '0;
        end else begin
            edgecap <= (edgecap & ~edge_clr) | edge_set;
            if (wr) begin
                case (bus.address)
                    GPIO_ADDR_DATA:    gpio_out <= wdata;
                    GPIO_ADDR_DIR:     gpio_oe  <= wdata;
                    GPIO_ADDR_IRQMASK: irqmask  <= wdata;
                    GPIO_ADDR_OUTSET:  gpio_out <= gpio_out | wdata;
                    GPIO_ADDR_OUTCLR:  gpio_out <= gpio_out & ~wdata;
                    default:           ;
                endcase
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (bus.address)
            GPIO_ADDR_DATA:    rd_word[WIDTH-1:0] = (gpio_oe & gpio_out) | (~gpio_oe & in_q);
            GPIO_ADDR_DIR:     rd_word[WIDTH-1:0] = gpio_oe;
            GPIO_ADDR_IRQMASK: rd_word[WIDTH-1:0] = irqmask;
            GPIO_ADDR_EDGECAP: rd_word[WIDTH-1:0] = edgecap;
            default:           ;
        endcase
    end

    // Output stage: read data held between strobes; irq one cycle behind EDGECAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (rd) begin
                bus.readdata <= rd_word;
            end
            irq <= |(edgecap & irqmask);
        end
    end

endmodule

// File: tb/tb_lms_gpio_ctrl.sv
// Randomised scoreboard bench for lms_gpio_ctrl (WIDTH=4, rising-edge capture)
// against a register-level reference model.
module tb_lms_gpio_ctrl;

`ifdef LMS_GPIO_DEBOUNCE_EN
    localparam int         LAT       = 16 + 3;
    localparam logic [3:0] WARM_PINS = 4'h0;
`else
    localparam int         LAT       = 3;
    localparam logic [3:0] WARM_PINS = 4'hF;
`endif
    localparam int SETTLE = LAT + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] gpio_in = 4'h0;
    logic [3:0] gpio_out;
    logic [3:0] gpio_oe;
    logic       irq;

    lms_gpio_if bus_if ();

    lms_gpio_ctrl #(
        .WIDTH       (4),
        .RESET_OUT   (4'h3),
        .RESET_DIR   (4'h0),
        .EDGE_TYPE   (0),
        .DEBOUNCE_CYC(16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if.slave),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0]  m_out, m_oe, m_mask, m_cap, m_pin;
    logic [31:0] exp_q[$];
    logic        rd_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a read strobe seen at a posedge means readdata is valid at the next negedge.
    always @(posedge clk) rd_vld <= bus_if.chipselect & ~bus_if.read_n;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL readdata: got %h with no expected value queued", bus_if.readdata);
            end else begin
                chk("readdata", bus_if.readdata, exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {28'h0, (m_oe & m_out) | (~m_oe & m_pin)};
            3'd1:    return {28'h0, m_oe};
            3'd2:    return {28'h0, m_mask};
            3'd3:    return {28'h0, m_cap};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_out  = 4'h3;
        m_oe   = 4'h0;
        m_mask = 4'h0;
        m_cap  = 4'h0;
    endtask

    task automatic bus_idle();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.read_n     = 1'b1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        logic [3:0] w;
        @(negedge clk);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        @(negedge clk);
        bus_idle();
        w = d[3:0];
        case (a)
            3'd0: m_out = w;
            3'd1: m_oe = w;
            3'd2: m_mask = w;
            3'd3: m_cap = m_cap & ~w;
            3'd4: m_out = m_out | w;
            3'd5: m_out = m_out & ~w;
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [2:0] a);
        @(negedge clk);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.read_n     = 1'b0;
        exp_q.push_back(model_read(a));
        @(negedge clk);
        bus_idle();
    endtask

    // Pin change: rising edges on input bits are captured once the change settles.
    task automatic set_pins(input logic [3:0] p);
        @(negedge clk);
        m_cap   = m_cap | (p & ~m_pin & ~m_oe);
        m_pin   = p;
        gpio_in = p;
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic check_pins(input string tag);
        @(negedge clk);
        chk({tag, ".gpio_out"}, 32'(gpio_out), 32'(m_out));
        chk({tag, ".gpio_oe"}, 32'(gpio_oe), 32'(m_oe));
        chk({tag, ".irq"}, 32'(irq), 32'(|(m_cap & m_mask)));
    endtask

    task automatic do_reset(input logic [3:0] pins);
        @(negedge clk);
        gpio_in = pins;
        reset   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        m_pin = pins;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        bus_if.address   = 3'd0;
        bus_if.writedata = 32'h0;
        model_reset();
        m_pin = 4'h0;

        // Reset state, then pins held high through reset release.
        do_reset(WARM_PINS);
        chk("rst.gpio_out", 32'(gpio_out), 32'h3);
        chk("rst.gpio_oe", 32'(gpio_oe), 32'h0);
        chk("rst.irq", 32'(irq), 32'h0);
        chk("rst.readdata", bus_if.readdata, 32'h0);
        repeat (SETTLE) @(negedge clk);
        bus_read(3'd3);

        set_pins(4'hA);
        bus_read(3'd0);

        // Outputs: DATA, OUTSET, OUTCLR, upper write bits ignored.
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_write(3'd0, 32'h1234_5675);
        bus_write(3'd4, 32'h0000_0008);
        bus_write(3'd5, 32'hFFFF_FFF1);
        check_pins("outs");
        chk("outs.value", 32'(gpio_out), 32'hC);
        bus_read(3'd0);
        bus_read(3'd6);

        // Edge latency and irq timing on bit1.
        bus_write(3'd1, 32'h0);
        set_pins(4'h0);
        bus_write(3'd3, 32'hF);
        bus_write(3'd2, 32'h2);
        check_pins("pre_edge");
        @(negedge clk);
        gpio_in = 4'h2;
        repeat (LAT) @(negedge clk);
        chk("irq_before_latency", 32'(irq), 32'h0);
        @(negedge clk);
        chk("irq_after_latency", 32'(irq), 32'h1);
        m_pin = 4'h2;
        m_cap = m_cap | 4'h2;
        bus_read(3'd3);
        bus_write(3'd3, 32'h2);
        check_pins("w1c");

        // New edge on bit0 coinciding with a W1C of bit0.
        set_pins(4'h3);
        set_pins(4'h2);
        @(negedge clk);
        gpio_in = 4'h3;
        repeat (LAT - 2) @(negedge clk);
        bus_write(3'd3, 32'h1);
        m_cap = m_cap | 4'h1;
        m_pin = 4'h3;
        repeat (SETTLE) @(negedge clk);
        bus_read(3'd3);

`ifdef LMS_GPIO_DEBOUNCE_EN
        // Short glitch is filtered; a long pulse is captured after debounce.
        set_pins(4'h0);
        bus_write(3'd3, 32'hF);
        bus_write(3'd2, 32'h4);
        @(negedge clk);
        gpio_in = 4'h4;
        repeat (10) @(negedge clk);
        gpio_in = 4'h0;
        repeat (30) @(negedge clk);
        chk("glitch.irq", 32'(irq), 32'h0);
        bus_read(3'd3);
        @(negedge clk);
        gpio_in = 4'h4;
        repeat (LAT) @(negedge clk);
        chk("pulse.irq_early", 32'(irq), 32'h0);
        @(negedge clk);
        chk("pulse.irq", 32'(irq), 32'h1);
        gpio_in = 4'h0;
        m_cap = m_cap | 4'h4;
        repeat (SETTLE) @(negedge clk);
        bus_read(3'd3);
`endif

        // Reset arriving together with a read strobe.
        @(negedge clk);
        bus_if.address    = 3'd1;
        bus_if.chipselect = 1'b1;
        bus_if.read_n     = 1'b0;
        reset             = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clk);
        bus_idle();
        reset = 1'b0;
        model_reset();
        chk("rst2.gpio_out", 32'(gpio_out), 32'h3);
        repeat (SETTLE) @(negedge clk);
        check_pins("rst2");

        // Randomised register and pin traffic.
        for (int i = 0; i < 400; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                bus_write(3'($urandom_range(0, 7)), $urandom);
            end else if (sel <= 7) begin
                bus_read(3'($urandom_range(0, 7)));
            end else if (sel == 8) begin
                set_pins(4'($urandom));
            end else begin
                check_pins("rand");
            end
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
